// File: rtl/servo_pwm.sv
// servo_pwm: frame-based servo pulse generator with per-frame slew-limited pulse width
module servo_pwm #(
  parameter int FRAME  = 1000000,
  parameter int CENTER = 75000,
  parameter int SMALL  = 12500,
  parameter int BIG    = 25000,
  parameter int STEP   = 2500,
  parameter int CW     = 20
) (
  input  logic       rst,
  input  logic       clk,
  input  logic [2:0] front_wheel,
  input  logic       en,
  output logic       pwm,
  output logic       settled,
  output logic       frame_start
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  logic          state;
  logic [CW-1:0] fcnt, cur, target, diff, nxt;
  logic          last, up;
  always_comb begin
    target = front_wheel == 3'b001 ? CW'(CENTER - SMALL) :
             front_wheel == 3'b011 ? CW'(CENTER - BIG) :
             front_wheel == 3'b101 ? CW'(CENTER + SMALL) :
             front_wheel == 3'b111 ? CW'(CENTER + BIG) : CW'(CENTER);
    up   = target > cur;
    diff = up ? target - cur : cur - target;
    // both operands stay inside [target, cur] so the step never wraps
    nxt  = diff <= CW'(STEP) ? target : up ? cur + CW'(STEP) : cur - CW'(STEP);
    last = fcnt == CW'(FRAME - 1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt        <= '0;
      cur         <= CW'(CENTER);
      state       <= IDLE;
      pwm         <= 1'b0;
      settled     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      fcnt <= last ? '0 : fcnt + 1'b1;
      if (last) begin
        state <= en ? RUN : IDLE;
        if (state == RUN) cur <= nxt;
      end
      pwm         <= state == RUN && fcnt < cur;
      frame_start <= fcnt == '0;
      settled     <= cur == target;
    end
  end
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: scoreboard bench; stimulus queues per-frame expected width/settled, monitor measures frames
module tb_servo_pwm;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b1;
  logic [2:0] front_wheel = 3'b000;
  logic       pwm, settled, frame_start;
  int checks = 0, errors = 0;
  typedef struct {int w; int s;} exp_t;
  exp_t q[$];
  exp_t e;
  int   cnt = 0, per = 0, s0 = 0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  servo_pwm #(.FRAME(100), .CENTER(50), .SMALL(10), .BIG(20), .STEP(5), .CW(8)) dut (
    .rst(rst), .clk(clk), .front_wheel(front_wheel), .en(en),
    .pwm(pwm), .settled(settled), .frame_start(frame_start)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 300);
    if (!frame_start) chk("frame_start_timeout", 0, 1);
  endtask

  // a frame window runs from one frame_start cycle up to the next
  always @(negedge clk) begin
    if (!rst) begin
      started = 1'b0;
      cnt = 0;
      per = 0;
    end else if (frame_start) begin
      if (started) begin
        chk("period", per, 100);
        if (q.size() == 0) chk("queue_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("width", cnt, e.w);
          chk("settled", s0, e.s);
        end
      end
      started = 1'b1;
      cnt = int'(pwm);
      per = 1;
      s0 = int'(settled);
    end else begin
      cnt += int'(pwm);
      per++;
    end
  end

  int         w_t [29] = '{0, 50, 50, 55, 60, 65, 70, 70, 65, 60, 55, 50, 45, 40, 35,
                           30, 35, 40, 40, 45, 50, 55, 60, 0, 0, 60, 65, 70, 65};
  int         s_t [29] = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0,
                           1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
  logic       en_t[29] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                           1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  logic [2:0] fw_t[29] = '{3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b010,
                           3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b001,
                           3'b001, 3'b001, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b111,
                           3'b111, 3'b111, 3'b111, 3'b000, 3'b000};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_settled", int'(settled), 1);
    chk("rst_frame_start", int'(frame_start), 0);
    rst = 1'b1;
    for (int i = 0; i < 29; i++) begin
      wait_fs();
      q.push_back('{w: w_t[i], s: s_t[i]});
      repeat (10) @(negedge clk);
      en = en_t[i];
      front_wheel = fw_t[i];
    end
    wait_fs();
    repeat (30) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("pwm_mid_pulse", int'(pwm), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm), 0);
    chk("async_rst_settled", int'(settled), 1);
    chk("async_rst_frame_start", int'(frame_start), 0);
    chk("async_rst_fcnt", int'(dut.fcnt), 0);
    chk("async_rst_cur", int'(dut.cur), 50);
    chk("async_rst_state", int'(dut.state), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_fs();
    q.push_back('{w: 0, s: 1});
    wait_fs();
    q.push_back('{w: 50, s: 1});
    wait_fs();
    @(negedge clk);
    #1;
    chk("final_queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
